// File: rtl/note_led_meter.sv
// note_led_meter
//   Multi-channel note meter. Each channel's tone frequency (Hz) is mapped to
//   a note class (1..7 = C..B, 0 = silence/unknown). A class sample raises a
//   7-LED meter that holds its peak for a few decay ticks and then falls one
//   step per tick. The LEDs can show the level as a bar or as a single dot.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   freq         packed frequencies, channel k at [k*FREQ_W +: FREQ_W]
//   freq_valid   per-channel sample strobe
//   mode         0 = bar (thermometer), 1 = dot (one-hot)
//   note_class   registered class per channel (3 bits each)
//   note_change  one-cycle pulse when a channel's class changes value
//   level        current meter level 0..7 per channel (3 bits each)
//   led          registered LED pattern per channel (7 bits each)
//
// Interface: freq_valid is a plain strobe with no backpressure. freq[k] is
// sampled on every rising edge where freq_valid[k] is 1 and ignored otherwise.
//
// Pipeline: sample at edge N -> note_class after N, level after N+1,
// led after N+2.
module note_led_meter #(
  parameter int CHANNELS     = 2,
  parameter int FREQ_W       = 32,
  parameter int DECAY_CYCLES = 25000000,
  parameter int HOLD_TICKS   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*FREQ_W-1:0]   freq,
  input  logic [CHANNELS-1:0]          freq_valid,
  input  logic                         mode,
  output logic [CHANNELS*3-1:0]        note_class,
  output logic [CHANNELS-1:0]          note_change,
  output logic [CHANNELS*3-1:0]        level,
  output logic [CHANNELS*7-1:0]        led
);

  localparam int PW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] PMAX  = PW'(DECAY_CYCLES - 1);
  localparam logic [HW-1:0] HLOAD = HW'(HOLD_TICKS);

  // Exact-match note lookup. Anything above 11 bits cannot be a note, so the
  // upper bits only need to be checked for zero.
  function automatic logic [2:0] classify(input logic [FREQ_W-1:0] f);
    logic [FREQ_W-1:0] upper;
    logic [2:0]        c;
    upper = f >> 11;
    c     = 3'd0;
    if (upper == '0) begin
      case (f[10:0])
        11'd131, 11'd262, 11'd277, 11'd524, 11'd554, 11'd1108: c = 3'd1;
        11'd147, 11'd294, 11'd311, 11'd588, 11'd622, 11'd1244: c = 3'd2;
        11'd165, 11'd330, 11'd660:                             c = 3'd3;
        11'd174, 11'd349, 11'd370, 11'd698, 11'd740, 11'd1480: c = 3'd4;
        11'd196, 11'd392, 11'd415, 11'd784, 11'd830, 11'd1660: c = 3'd5;
        11'd220, 11'd440, 11'd466, 11'd880, 11'd932, 11'd1864: c = 3'd6;
        11'd247, 11'd494, 11'd988, 11'd1976:                   c = 3'd7;
        default:                                               c = 3'd0;
      endcase
    end
    return c;
  endfunction

  // Shared decay prescaler; tick marks the last count of each period.
  logic [PW-1:0] pcount;
  logic          tick;

  assign tick = (pcount == PMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcount <= '0;
    end else if (tick) begin
      pcount <= '0;
    end else begin
      pcount <= pcount + PW'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [2:0]    cls_q;
    logic          chg_q;
    logic          fresh_q;   // cls_q was loaded on the previous edge
    logic [2:0]    lvl_q;
    logic [2:0]    lvl_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [6:0]    led_q;
    logic [6:0]    led_d;
    logic [2:0]    cls_new;

    assign cls_new = classify(freq[k*FREQ_W +: FREQ_W]);

    // Stage 1: class register and change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cls_q   <= 3'd0;
        chg_q   <= 1'b0;
        fresh_q <= 1'b0;
      end else begin
        fresh_q <= freq_valid[k];
        if (freq_valid[k]) begin
          cls_q <= cls_new;
          chg_q <= (cls_new != cls_q);
        end else begin
          chg_q <= 1'b0;
        end
      end
    end

    // Stage 2: peak load / hold / decay. Only a freshly sampled class can
    // load the meter; the held class register alone would otherwise pin the
    // level forever after a single strobe. Repeated strobes of the same note
    // keep reloading hold, so a sustained note never decays.
    always_comb begin
      lvl_d  = lvl_q;
      hold_d = hold_q;
      if (fresh_q && (cls_q != 3'd0) && (cls_q >= lvl_q)) begin
        lvl_d  = cls_q;
        hold_d = HLOAD;
      end else if (tick && (hold_q != '0)) begin
        hold_d = hold_q - HW'(1);
      end else if (tick && (lvl_q != 3'd0)) begin
        lvl_d = lvl_q - 3'd1;
      end
    end

    // Stage 3: LED pattern from the current level.
    always_comb begin
      led_d = 7'd0;
      if (lvl_q != 3'd0) begin
        if (mode) begin
          led_d = 7'd1 << (lvl_q - 3'd1);
        end else begin
          for (int i = 0; i < 7; i++) begin
            led_d[i] = (3'(i) < lvl_q);
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl_q  <= 3'd0;
        hold_q <= '0;
        led_q  <= 7'd0;
      end else begin
        lvl_q  <= lvl_d;
        hold_q <= hold_d;
        led_q  <= led_d;
      end
    end

    assign note_class[k*3 +: 3] = cls_q;
    assign note_change[k]       = chg_q;
    assign level[k*3 +: 3]      = lvl_q;
    assign led[k*7 +: 7]        = led_q;
  end

endmodule

// File: tb/tb_note_led_meter.sv
// Testbench for note_led_meter (CHANNELS=2, FREQ_W=32, DECAY_CYCLES=4,
// HOLD_TICKS=2). A behavioural model advances on every rising edge and all
// outputs are compared against it half a cycle later; directed sequences add
// explicit constant expectations for the corner cases.
module tb_note_led_meter;

  localparam int CH = 2;
  localparam int FW = 32;
  localparam int DC = 4;
  localparam int HT = 2;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH*FW-1:0] freq = '0;
  logic [CH-1:0]   freq_valid = '0;
  logic            mode = 1'b0;
  logic [CH*3-1:0] note_class;
  logic [CH-1:0]   note_change;
  logic [CH*3-1:0] level;
  logic [CH*7-1:0] led;

  always #5 clk = ~clk;

  note_led_meter #(
    .CHANNELS(CH), .FREQ_W(FW), .DECAY_CYCLES(DC), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .freq(freq), .freq_valid(freq_valid),
    .mode(mode), .note_class(note_class), .note_change(note_change),
    .level(level), .led(led)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int note_freqs[7][6] = '{
    '{131, 262, 277, 524, 554, 1108},
    '{147, 294, 311, 588, 622, 1244},
    '{165, 330, 660, -1, -1, -1},
    '{174, 349, 370, 698, 740, 1480},
    '{196, 392, 415, 784, 830, 1660},
    '{220, 440, 466, 880, 932, 1864},
    '{247, 494, 988, 1976, -1, -1}
  };

  int m_cls[CH], m_chg[CH], m_lvl[CH], m_hold[CH], m_led[CH], m_fresh[CH];
  int m_cnt;

  function automatic int ref_class(input logic [31:0] f);
    for (int c = 0; c < 7; c++)
      for (int j = 0; j < 6; j++)
        if (note_freqs[c][j] >= 0 && f == 32'(note_freqs[c][j])) return c + 1;
    return 0;
  endfunction

  function automatic int ref_led(input int lv, input logic md);
    if (lv == 0) return 0;
    if (md) return 1 << (lv - 1);
    return (1 << lv) - 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_cls[k] = 0; m_chg[k] = 0; m_lvl[k] = 0;
      m_hold[k] = 0; m_led[k] = 0; m_fresh[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_edge();
    bit tick;
    int nc;
    tick = (m_cnt == DC - 1);
    for (int k = 0; k < CH; k++) begin
      m_led[k] = ref_led(m_lvl[k], mode);
      if (m_fresh[k] != 0 && m_cls[k] != 0 && m_cls[k] >= m_lvl[k]) begin
        m_lvl[k]  = m_cls[k];
        m_hold[k] = HT;
      end else if (tick && m_hold[k] != 0) begin
        m_hold[k]--;
      end else if (tick && m_lvl[k] != 0) begin
        m_lvl[k]--;
      end
      if (freq_valid[k]) begin
        nc = ref_class(freq[k*FW +: FW]);
        m_chg[k] = (nc != m_cls[k]) ? 1 : 0;
        m_cls[k] = nc;
      end else begin
        m_chg[k] = 0;
      end
      m_fresh[k] = freq_valid[k] ? 1 : 0;
    end
    m_cnt = (m_cnt + 1) % DC;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [13:0] act, exp;
    for (int k = 0; k < CH; k++) begin
      act = {note_class[k*3 +: 3], note_change[k], level[k*3 +: 3], led[k*7 +: 7]};
      exp = {3'(m_cls[k]), 1'(m_chg[k]), 3'(m_lvl[k]), 7'(m_led[k])};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_ch%0d @%0t: got cls=%0d chg=%0d lvl=%0d led=%07b expected cls=%0d chg=%0d lvl=%0d led=%07b",
                 k, $time, act[13:11], act[10], act[9:7], act[6:0],
                 exp[13:11], exp[10], exp[9:7], exp[6:0]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model follows the DUT edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input int k, input logic [31:0] f, input bit v);
    freq[k*FW +: FW] = f;
    freq_valid[k]    = v;
  endtask

  function automatic logic [31:0] pick_freq();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel <= 1) return 32'(note_freqs[$urandom_range(0, 6)][$urandom_range(0, 2)]);
    if (sel == 2) return 32'($urandom_range(0, 2100));
    return $urandom;
  endfunction

  typedef struct {
    logic [31:0] f;
    int          exp_cls;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int guard;

    vecs.push_back('{32'd131, 1});  vecs.push_back('{32'd1244, 2});
    vecs.push_back('{32'd660, 3});  vecs.push_back('{32'd1480, 4});
    vecs.push_back('{32'd415, 5});  vecs.push_back('{32'd1864, 6});
    vecs.push_back('{32'd247, 7});  vecs.push_back('{32'd1976, 7});
    vecs.push_back('{32'd0, 0});    vecs.push_back('{32'd441, 0});
    vecs.push_back('{32'd130, 0});  vecs.push_back('{32'hFFFF_0106, 0});
    vecs.push_back('{32'h0000_0806, 0}); vecs.push_back('{32'd554, 1});

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_class", 32'(note_class), 32'd0);
    check("reset_change", 32'(note_change), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_led", 32'(led), 32'd0);
    rst_n = 1'b1;

    // Scenario 1: single 440 strobe on ch0
    drive(0, 32'd440, 1'b1);
    step();
    check("s1_class0", 32'(note_class[2:0]), 32'd6);
    check("s1_change0", 32'(note_change[0]), 32'd1);
    drive(0, 32'd440, 1'b0);
    step();
    check("s1_level0", 32'(level[2:0]), 32'd6);
    check("s1_change0_clr", 32'(note_change[0]), 32'd0);
    step();
    check("s1_led0", 32'(led[6:0]), 32'h3F);
    check("s1_ch1_idle", 32'({note_class[5:3], level[5:3], led[13:7]}), 32'd0);

    // Scenario 2: hold then decay to zero
    repeat (3) step();
    check("s2_holding", 32'(level[2:0]), 32'd6);
    repeat (40) step();
    check("s2_level_zero", 32'(level[2:0]), 32'd0);
    check("s2_led_zero", 32'(led[6:0]), 32'd0);

    // Scenario 3: simultaneous strobes, then dot mode
    drive(0, 32'd131, 1'b1);
    drive(1, 32'd1976, 1'b1);
    step();
    check("s3_class0", 32'(note_class[2:0]), 32'd1);
    check("s3_class1", 32'(note_class[5:3]), 32'd7);
    drive(0, 32'd131, 1'b0);
    drive(1, 32'd1976, 1'b0);
    repeat (2) step();
    check("s3_bar_led1", 32'(led[13:7]), 32'h7F);
    check("s3_bar_led0", 32'(led[6:0]), 32'h01);
    mode = 1'b1;
    step();
    check("s3_dot_led1", 32'(led[13:7]), 32'h40);
    check("s3_dot_led0", 32'(led[6:0]), 32'h01);
    mode = 1'b0;
    repeat (40) step();

    // Scenario 4: lower class ignored, reload landing on a tick edge
    drive(0, 32'd784, 1'b1);
    step();
    drive(0, 32'd784, 1'b0);
    guard = 0;
    while (m_lvl[0] != 4 && guard < 100) begin step(); guard++; end
    check("s4_reach_l4", 32'(guard < 100), 32'd1);
    drive(0, 32'd262, 1'b1);
    step();
    check("s4_change_low", 32'(note_change[0]), 32'd1);
    check("s4_class_low", 32'(note_class[2:0]), 32'd1);
    drive(0, 32'd262, 1'b0);
    step();
    check("s4_change_once", 32'(note_change[0]), 32'd0);
    guard = 0;
    while (m_lvl[0] != 3 && guard < 100) begin step(); guard++; end
    check("s4_reach_l3", 32'(guard < 100), 32'd1);
    guard = 0;
    while (m_cnt != DC - 2 && guard < 10) begin step(); guard++; end
    drive(0, 32'd784, 1'b1);
    step();
    drive(0, 32'd784, 1'b0);
    check("s4_on_tick_edge", 32'(m_cnt == DC - 1), 32'd1);
    step();
    check("s4_reload_level", 32'(level[2:0]), 32'd5);
    repeat (DC) step();
    check("s4_held_after_tick", 32'(level[2:0]), 32'd5);

    // Scenario 5: non-notes give class 0 and leave the meter alone
    drive(0, 32'd441, 1'b1);
    step();
    check("s5_441", 32'(note_class[2:0]), 32'd0);
    drive(0, 32'd0, 1'b1);
    step();
    check("s5_zero", 32'(note_class[2:0]), 32'd0);
    drive(0, 32'hFFFF_0106, 1'b1);
    step();
    check("s5_upper", 32'(note_class[2:0]), 32'd0);
    drive(0, 32'd0, 1'b0);
    repeat (3) step();

    // Classification table on ch1
    foreach (vecs[i]) begin
      drive(1, vecs[i].f, 1'b1);
      step();
      check($sformatf("tab_%0d", vecs[i].f), 32'(note_class[5:3]), 32'(vecs[i].exp_cls));
    end
    drive(1, 32'd0, 1'b0);
    repeat (40) step();

    // Scenario 6: asynchronous reset mid-hold at level 7
    drive(0, 32'd988, 1'b1);
    step();
    drive(0, 32'd988, 1'b0);
    repeat (2) step();
    check("s6_level7", 32'(level[2:0]), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_class", 32'(note_class), 32'd0);
    check("s6_async_level", 32'(level), 32'd0);
    check("s6_async_led", 32'(led), 32'd0);
    check("s6_async_change", 32'(note_change), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'd440, 1'b1);
    step();
    drive(0, 32'd440, 1'b0);
    repeat (12) step();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < CH; k++) begin
        drive(k, pick_freq(), ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
